// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load.
// Serial outputs are taken from both ends, and q exposes the full state.
// A shift counter pulses frame_done for one cycle on every WIDTH-th shift
// since the last load or reset. Left and right shifts count toward the
// same frame, and a load always starts a new frame.
module univ_shift_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    localparam int                CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    // A shift happens only with en high and a shift mode selected.
    logic do_shift;
    assign do_shift = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));

    // Register, shift counter and frame pulse are updated together so that
    // a load on the completing shift cycle cleanly suppresses the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= RST_VAL;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_RIGHT: q <= {sin_r, q[WIDTH-1:1]};
                    MODE_LEFT:  q <= {q[WIDTH-2:0], sin_l};
                    MODE_LOAD: begin
                        q         <= pdin;
                        shift_cnt <= '0;
                    end
                    MODE_HOLD:  q <= q;
                    default:    q <= q;
                endcase
            end
            if (do_shift) begin
                if (shift_cnt == CNT_LAST) begin
                    shift_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + CW'(1);
                end
            end
        end
    end

    // End bits are combinational so they track q right after each edge.
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register and the successor to the fixed 4-bit SISO stage. Width is generic. Modes are hold, shift-right, shift-left and parallel load. Serial outputs are provided at both ends and the full parallel state is exposed. A shift counter raises a one-cycle frame_done pulse after exactly WIDTH shifts since the last load or reset, so serialiser and deserialiser blocks can use it to frame data.

Parameters:
WIDTH, 8, register width in bits; legal range is 2 or more.
RST_VAL, 0, WIDTH-bit value loaded into q on reset.
CW, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  operation enable; when low, the register holds regardless of mode.
mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
sin_r  in  1  serial input for a right shift; enters q[WIDTH-1].
sin_l  in  1  serial input for a left shift; enters q[0].
pdin  in  WIDTH  parallel load data.
q  out  WIDTH  register contents.
sout_r  out  1  equals q[0]; bit leaving on a right shift.
sout_l  out  1  equals q[WIDTH-1]; bit leaving on a left shift.
shift_cnt  out  CW  number of shifts since the last load, reset or frame completion.
frame_done  out  1  registered one-cycle pulse marking the WIDTH-th shift.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: q=RST_VAL, shift_cnt=0, frame_done=0.
  - Reset takes effect immediately, with no clock needed, including mid-frame. Any partial frame is discarded.
  - After rst_n is released, the first operation happens at the next rising edge.
- Operation select, with en=1:
  - mode 00: q, shift_cnt and frame_done all hold; frame_done is forced to 0.
  - mode 01: q <= {sin_r, q[WIDTH-1:1]}.
  - mode 10: q <= {q[WIDTH-2:0], sin_l}.
  - mode 11: q <= pdin; shift_cnt <= 0; frame_done <= 0.
- en=0 behaves exactly like mode 00 for every mode value.
- Latency: q updates on the edge where the operation is sampled. sout_r and sout_l are combinational from q, so they show the new end bits immediately after that edge.
- Shift counting:
  - Each shift (mode 01 or 10 with en=1) increments shift_cnt.
  - On the shift where shift_cnt==WIDTH-1: shift_cnt wraps to 0 and frame_done <= 1 on that same edge.
  - On every other edge frame_done <= 0. It is therefore high for exactly one cycle per completed frame.
  - Left and right shifts both count toward the same frame. Changing direction mid-frame does not reset the counter.
  - Hold cycles in the middle of a frame keep shift_cnt and do not extend frame_done.
- Back-to-back frames: when shifting continues every cycle, frame_done pulses every WIDTH cycles. Consecutive pulses cannot occur because WIDTH is 2 or more.
- Load during the completing shift cycle: the load wins. shift_cnt=0, frame_done=0, and no pulse is issued.
- Ranges: shift_cnt never exceeds WIDTH-1, and q is never X after reset.
- Implementation: a single sequential process updates q, shift_cnt and frame_done; there are no latches.

Test Plan:
- Reset (WIDTH=8, RST_VAL=0): pulse rst_n low between clock edges -> q=0x00, shift_cnt=0 and frame_done=0 immediately, without waiting for an edge.
- Load and right shift:
  - Stimulus: mode=11 with pdin=0xA5, then 8 cycles of mode=01 with sin_r=0.
  - sout_r after the load and after each of the first 7 shifts reads 1,0,1,0,0,1,0,1.
  - q=0x00 after the 8th shift; frame_done=1 for exactly that cycle; shift_cnt returns to 0.
- Left shift fill: from 0x00, 4 cycles of mode=10 with sin_l=1 -> q=0x0F, sout_l=0, shift_cnt=4, frame_done=0.
- Enable gating: en=0 with mode=11 and pdin=0xFF for 3 cycles -> q and shift_cnt unchanged, frame_done=0.
- Reset mid-frame:
  - Stimulus: 3 right shifts of sin_r=1, then rst_n low for one cycle and released.
  - Expected: q=0x00 and shift_cnt=0 after reset. A further 8 shifts are required before frame_done pulses; 7 shifts produce no pulse.
- Load on the completing shift:
  - Stimulus: after 7 shifts, apply mode=11 with pdin=0x3C.
  - Expected: q=0x3C, shift_cnt=0, frame_done stays 0. After 16 continuous shifts that follow, frame_done pulses exactly twice, 8 cycles apart.
